challenge_generator: RTL and testbench
======================================

Name: challenge_generator

Overview:
- Sequential source of 64-bit PUF challenges.
- Sits directly upstream of the input network in the XOR-PUF datapath and drives its x input.
- Produces a programmable-length sequence of pseudo-random challenges from a seeded 64-bit Fibonacci LFSR (x^64+x^63+x^61+x^60+1).
- Each challenge is released under a valid/ready handshake so the PUF evaluation/response capture stage can throttle it.

Parameters:
- WIDTH, 64, challenge and LFSR width; taps are fixed for 64.
- CNT_W, 16, width of challenge-count request and counter.
- RST_SEED, 64'h0000000000000001, LFSR value after reset; must be nonzero.

Ports:
- clk, input, 1, system clock; all state on rising edge.
- rst, input, 1, synchronous active-high reset.
- seed_load, input, 1, load seed into LFSR (honoured only in IDLE).
- seed, input, WIDTH, seed value.
- start, input, 1, begin sequence (honoured only in IDLE).
- num_chal, input, CNT_W, number of challenges to emit; sampled on start.
- chal, output, WIDTH, current challenge, to input network x.
- chal_valid, output, 1, chal holds an unconsumed challenge.
- chal_ready, input, 1, downstream accepts chal this cycle.
- busy, output, 1, high in RUN.
- done, output, 1, one-cycle pulse at sequence end.
- chal_count, output, CNT_W, challenges accepted since last start.

Behaviour:
- One clock, synchronous active-high reset.
- Reset values:
  - state=IDLE, lfsr=RST_SEED, chal=RST_SEED, chal_valid=0, busy=0, done=0, chal_count=0, target register=0.
- LFSR step: fb = s[63]^s[62]^s[60]^s[59]; next = {s[62:0], fb}. chal is always the registered LFSR value.
- States:
  - IDLE:
    - seed_load=1 → lfsr<=seed next cycle; seed==0 is replaced by 64'h1 (lock-up guard).
    - start=1 with num_chal!=0 → latch target=num_chal, chal_count<=0, go RUN; chal_valid=1 and busy=1 from the next cycle.
    - start=1 with num_chal==0 → go DONE directly; no challenge emitted.
    - seed_load and start in the same cycle → seed loads first; the sequence begins with the new seed.
  - RUN:
    - chal_valid=1 throughout.
    - chal_valid&chal_ready → chal_count+1; LFSR advances.
    - If new count==target → go DONE, chal_valid<=0 next cycle; otherwise the next challenge is presented next cycle.
    - Throughput is one challenge per cycle with chal_ready held high.
    - chal_valid&!chal_ready → chal and chal_valid held stable (no advance).
    - seed_load and start are ignored.
  - DONE:
    - done=1 for exactly one cycle; busy=0, chal_valid=0; return to IDLE.
    - LFSR retains the state following the last accepted challenge, so the next start continues the sequence unless reseeded.
- chal_count saturates at target, never wraps. CNT_W=16 allows up to 65535 challenges per run.
- Reset asserted mid-RUN aborts immediately: all reset values apply next cycle, no done pulse.
- The latency from start to first chal_valid is 1 cycle.

Test Plan:
- Reset, then seed_load seed=64'h1; start num_chal=3, chal_ready=1 → chal 64'h1, 64'h2, 64'h4 on three consecutive cycles; done pulses the cycle after the 3rd accept; chal_count=3.
- Seed 64'h8000000000000000, num_chal=2 → chal 64'h8000000000000000 then 64'h0000000000000001 (feedback bit=1).
- num_chal=4, chal_ready toggled 1,0,0,1,1,0,1 → chal frozen during ready=0; exactly 4 distinct accepted values 1,2,4,8; done after the 4th accept; chal_valid never drops early.
- seed_load seed=0 in IDLE, then start num_chal=1 → emitted chal=64'h1. start with num_chal=0 → done pulse the next cycle, chal_valid stays 0.
- Mid-RUN (after 2 of 5 accepts) assert rst for 1 cycle → chal_valid=0, busy=0, chal_count=0, chal=64'h1, no done. seed_load/start pulsed during RUN → ignored, sequence unchanged.
- Two back-to-back runs num_chal=2 each without reseed from seed 1 → second run emits 64'h4, 64'h8.

Source files
------------

// File: rtl/challenge_generator_if.sv
// Challenge handshake bundle between the challenge generator and the PUF input network.
interface challenge_generator_if #(
    parameter int WIDTH = 64
);
    logic [WIDTH-1:0] chal;
    logic             chal_valid;
    logic             chal_ready;

    modport master (output chal, output chal_valid, input chal_ready);
    modport slave  (input chal, input chal_valid, output chal_ready);
endinterface

// File: rtl/challenge_generator.sv
// Seeded 64-bit Fibonacci LFSR (x^64+x^63+x^61+x^60+1) emitting a programmable
// number of PUF challenges over a valid/ready handshake.
module challenge_generator #(
    parameter int               WIDTH    = 64,
    parameter int               CNT_W    = 16,
    parameter logic [WIDTH-1:0] RST_SEED = WIDTH'(1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   seed_load,
    input  logic [WIDTH-1:0]       seed,
    input  logic                   start,
    input  logic [CNT_W-1:0]       num_chal,
    challenge_generator_if.master  chal_if,
    output logic                   busy,
    output logic                   done,
    output logic [CNT_W-1:0]       chal_count
);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t           state;
    logic [WIDTH-1:0] lfsr;
    logic [CNT_W-1:0] target;
    logic             valid_q;

    logic             fb;
    logic [WIDTH-1:0] lfsr_next;
    logic [CNT_W-1:0] count_inc;

    assign fb        = lfsr[WIDTH-1] ^ lfsr[WIDTH-2] ^ lfsr[WIDTH-4] ^ lfsr[WIDTH-5];
    assign lfsr_next = {lfsr[WIDTH-2:0], fb};
    assign count_inc = chal_count + CNT_W'(1);

    assign chal_if.chal       = lfsr;
    assign chal_if.chal_valid = valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lfsr       <= RST_SEED;
            valid_q    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            chal_count <= '0;
            target     <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    // An all-zero seed would lock the LFSR up, so it is replaced by 1.
                    if (seed_load)
                        lfsr <= (seed == '0) ? WIDTH'(1) : seed;
                    if (start) begin
                        chal_count <= '0;
                        target     <= num_chal;
                        if (num_chal != '0) begin
                            state   <= RUN;
                            valid_q <= 1'b1;
                            busy    <= 1'b1;
                        end else begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (chal_if.chal_ready) begin
                        chal_count <= count_inc;
                        lfsr       <= lfsr_next;
                        if (count_inc == target) begin
                            state   <= FINISH;
                            valid_q <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end
                    end
                end
                FINISH:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_challenge_generator.sv
// Randomized and directed bench for challenge_generator: cycle model plus
// per-run accepted-challenge scoreboard, pinned by literal sequences.
module tb_challenge_generator;

    localparam logic [63:0] TAP_MASK = 64'hD800_0000_0000_0000;

    logic        clk;
    logic        rst;
    logic        seed_load;
    logic [63:0] seed;
    logic        start;
    logic [15:0] num_chal;
    logic        busy;
    logic        done;
    logic [15:0] chal_count;

    challenge_generator_if #(.WIDTH(64)) cif ();

    challenge_generator #(
        .WIDTH   (64),
        .CNT_W   (16),
        .RST_SEED(64'h1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .seed_load (seed_load),
        .seed      (seed),
        .start     (start),
        .num_chal  (num_chal),
        .chal_if   (cif),
        .busy      (busy),
        .done      (done),
        .chal_count(chal_count)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit checking = 0;
    logic [63:0] acc_log[$];
    logic [63:0] cur;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] step(input logic [63:0] s);
        return {s[62:0], ^(s & TAP_MASK)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_list(input string name, input logic [63:0] exp[$]);
        chk({name, "_len"}, 64'(acc_log.size()), 64'(exp.size()));
        foreach (exp[i])
            if (i < acc_log.size())
                chk($sformatf("%s[%0d]", name, i), acc_log[i], exp[i]);
    endtask

    // Behavioural model: phase flags plus the value sequence position.
    logic [63:0] m_lfsr   = 64'h1;
    bit          m_active = 0;
    bit          m_done   = 0;
    int          m_count  = 0;
    int          m_target = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_lfsr = 64'h1; m_active = 0; m_done = 0; m_count = 0; m_target = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_active) begin
            if (cif.chal_ready) begin
                m_count++;
                m_lfsr = step(m_lfsr);
                if (m_count == m_target) begin
                    m_active = 0;
                    m_done   = 1;
                end
            end
        end else begin
            if (seed_load) m_lfsr = (seed == 64'h0) ? 64'h1 : seed;
            if (start) begin
                m_count = 0;
                if (num_chal == 16'h0) m_done = 1;
                else begin
                    m_target = int'(num_chal);
                    m_active = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("chal",       cif.chal,             m_lfsr);
            chk("chal_valid", 64'(cif.chal_valid),  64'(m_active));
            chk("busy",       64'(busy),            64'(m_active));
            chk("done",       64'(done),            64'(m_done));
            chk("chal_count", 64'(chal_count),      64'(m_count));
            if (cif.chal_valid && cif.chal_ready) acc_log.push_back(cif.chal);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Runs one sequence from IDLE and checks the accepted values against the
    // chained LFSR sequence from the high-level start value.
    task automatic run(input bit do_seed, input logic [63:0] s, input int n,
                       input int ready_mode, input bit poke);
        int          pat[7] = '{1, 0, 0, 1, 1, 0, 1};
        logic [63:0] exp[$];
        logic [63:0] v;
        int          k;
        bit          seen;
        v = do_seed ? ((s == 64'h0) ? 64'h1 : s) : cur;
        for (int i = 0; i < n; i++) begin
            exp.push_back(v);
            v = step(v);
        end
        acc_log.delete();
        seed_load = do_seed; seed = s; start = 1'b1; num_chal = 16'(n);
        cyc();
        k = 0; seen = 0;
        while (!seen && k < 500) begin
            case (ready_mode)
                0:       cif.chal_ready = 1'b1;
                1:       cif.chal_ready = pat[k % 7] != 0;
                default: cif.chal_ready = ($urandom_range(9) < 7);
            endcase
            if (poke && k == 1) begin
                seed_load = 1'b1; seed = {$urandom, $urandom}; start = 1'b1; num_chal = 16'd7;
            end else begin
                seed_load = 1'b0; start = 1'b0;
            end
            @(negedge clk);
            if (done) begin
                seen = 1;
                chk("count_at_done", 64'(chal_count), 64'(n));
            end else begin
                cyc();
            end
            k++;
        end
        if (!seen) chk("done_timeout", 64'(0), 64'(1));
        chk_list("accepted", exp);
        cur = v;
        seed_load = 1'b0; start = 1'b0;
        cyc();
        cif.chal_ready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [63:0] lit[$];
        rst = 1'b1; seed_load = 1'b0; seed = '0; start = 1'b0; num_chal = '0;
        cif.chal_ready = 1'b0;
        cur = 64'h1;
        cyc(); cyc();
        chk("rst_chal",  cif.chal,            64'h1);
        chk("rst_valid", 64'(cif.chal_valid), 64'h0);
        chk("rst_busy",  64'(busy),           64'h0);
        chk("rst_done",  64'(done),           64'h0);
        chk("rst_count", 64'(chal_count),     64'h0);
        rst = 1'b0;
        checking = 1;
        cyc();

        seed_load = 1'b1; seed = 64'h1; cyc(); seed_load = 1'b0; cur = 64'h1;
        run(0, 64'h0, 3, 0, 0);
        lit = '{64'h1, 64'h2, 64'h4};
        chk_list("lit_seed1", lit);

        run(1, 64'h8000_0000_0000_0000, 2, 0, 0);
        lit = '{64'h8000_0000_0000_0000, 64'h1};
        chk_list("lit_msb", lit);

        run(1, 64'h1, 4, 1, 0);
        lit = '{64'h1, 64'h2, 64'h4, 64'h8};
        chk_list("lit_throttle", lit);

        run(1, 64'h0, 1, 0, 0);
        lit = '{64'h1};
        chk_list("lit_zero_seed", lit);

        run(0, 64'h0, 0, 0, 0);
        chk("zero_count_len", 64'(acc_log.size()), 64'h0);

        acc_log.delete();
        seed_load = 1'b1; seed = 64'h1; start = 1'b1; num_chal = 16'd5; cyc();
        seed_load = 1'b0; start = 1'b0; cif.chal_ready = 1'b1;
        cyc(); cyc();
        rst = 1'b1; cif.chal_ready = 1'b0;
        cyc();
        rst = 1'b0;
        chk("abort_valid", 64'(cif.chal_valid), 64'h0);
        chk("abort_busy",  64'(busy),           64'h0);
        chk("abort_count", 64'(chal_count),     64'h0);
        chk("abort_chal",  cif.chal,            64'h1);
        chk("abort_done",  64'(done),           64'h0);
        chk("abort_accepts", 64'(acc_log.size()), 64'h2);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("abort_no_done", 64'(done), 64'h0);
        end
        cur = 64'h1;

        run(0, 64'h0, 4, 0, 1);
        lit = '{64'h1, 64'h2, 64'h4, 64'h8};
        chk_list("lit_ignore_ctl", lit);

        run(1, 64'h1, 2, 0, 0);
        run(0, 64'h0, 2, 0, 0);
        lit = '{64'h4, 64'h8};
        chk_list("lit_back_to_back", lit);

        for (int r = 0; r < 30; r++) begin
            bit          ds;
            logic [63:0] sv;
            ds = ($urandom_range(2) == 0);
            sv = ($urandom_range(4) == 0) ? 64'h0 : {$urandom, $urandom};
            run(ds, sv, int'($urandom_range(12)), 2, ($urandom_range(3) == 0));
        end

        checking = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
